// File: rtl/ld_rs_pkg.sv
// Shared types and constants for the load reservation station.
package ld_rs_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned TAG_W  = 6;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned PC_W   = 16;

  localparam logic [OP_W-1:0] OP_LD  = 4'd4;
  localparam logic [OP_W-1:0] OP_LDR = 4'd5;

  // Fields handed to the load unit on issue.
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] val0;
    logic [DATA_W-1:0] val1;
  } ld_payload_t;

  localparam ld_payload_t         PAYLOAD_RST = '0;
  localparam logic [TAG_W-1:0]    TAG_RST     = '0;

endpackage

// File: rtl/ld_rs_entry.sv
// One reservation-station entry: storage, CDB capture and ready flag.
module ld_rs_entry
  import ld_rs_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc,
  input  logic              free,
  input  logic [OP_W-1:0]   disp_op,
  input  logic [PC_W-1:0]   disp_pc,
  input  logic              disp_rdy0,
  input  logic              disp_rdy1,
  input  logic [DATA_W-1:0] disp_val0,
  input  logic [DATA_W-1:0] disp_val1,
  input  logic [TAG_W-1:0]  disp_tag0,
  input  logic [TAG_W-1:0]  disp_tag1,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_rs_num,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              valid,
  output logic [OP_W-1:0]   op,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] val0,
  output logic [DATA_W-1:0] val1,
  output logic              ready_c
);

  logic              valid_q, valid_d;
  logic              rdy0_q, rdy0_d, rdy1_q, rdy1_d;
  logic [TAG_W-1:0]  tag0_q, tag0_d, tag1_q, tag1_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0] val0_q, val0_d, val1_q, val1_d;

  // Next-state: allocate (with same-cycle CDB bypass), free on issue, or snoop the CDB.
  always_comb begin
    valid_d = valid_q;
    rdy0_d  = rdy0_q;
    rdy1_d  = rdy1_q;
    tag0_d  = tag0_q;
    tag1_d  = tag1_q;
    op_d    = op_q;
    pc_d    = pc_q;
    val0_d  = val0_q;
    val1_d  = val1_q;
    if (alloc) begin
      valid_d = 1'b1;
      op_d    = disp_op;
      pc_d    = disp_pc;
      tag0_d  = disp_tag0;
      tag1_d  = disp_tag1;
      rdy0_d  = disp_rdy0;
      val0_d  = disp_val0;
      rdy1_d  = disp_rdy1;
      val1_d  = disp_val1;
      if (!disp_rdy0 && cdb_valid && (cdb_rs_num == disp_tag0)) begin
        rdy0_d = 1'b1;
        val0_d = cdb_data;
      end
      if (!disp_rdy1 && cdb_valid && (cdb_rs_num == disp_tag1)) begin
        rdy1_d = 1'b1;
        val1_d = cdb_data;
      end
    end else if (free) begin
      valid_d = 1'b0;
    end else if (valid_q && cdb_valid) begin
      if (!rdy0_q && (cdb_rs_num == tag0_q)) begin
        rdy0_d = 1'b1;
        val0_d = cdb_data;
      end
      if (!rdy1_q && (cdb_rs_num == tag1_q)) begin
        rdy1_d = 1'b1;
        val1_d = cdb_data;
      end
    end
  end

  // Entry state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      rdy0_q  <= 1'b0;
      rdy1_q  <= 1'b0;
      tag0_q  <= TAG_RST;
      tag1_q  <= TAG_RST;
      op_q    <= PAYLOAD_RST.op;
      pc_q    <= PAYLOAD_RST.pc;
      val0_q  <= PAYLOAD_RST.val0;
      val1_q  <= PAYLOAD_RST.val1;
    end else begin
      valid_q <= valid_d;
      rdy0_q  <= rdy0_d;
      rdy1_q  <= rdy1_d;
      tag0_q  <= tag0_d;
      tag1_q  <= tag1_d;
      op_q    <= op_d;
      pc_q    <= pc_d;
      val0_q  <= val0_d;
      val1_q  <= val1_d;
    end
  end

  assign valid   = valid_q;
  assign op      = op_q;
  assign pc      = pc_q;
  assign val0    = val0_q;
  assign val1    = val1_q;
  // LD needs only operand 0; LDR needs both.
  assign ready_c = valid_q && rdy0_q && ((op_q == OP_LD) || rdy1_q);

endmodule

// File: rtl/ld_rs.sv
// Load reservation-station bank: allocates dispatches, snoops the CDB, issues one ready load at a time.
module ld_rs
  import ld_rs_pkg::*;
#(
  parameter int unsigned N_ENTRIES = 4,
  parameter logic [5:0]  RS_BASE   = 6'd16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        disp_valid,
  input  logic [3:0]  disp_op,
  input  logic [15:0] disp_pc,
  input  logic        disp_rdy0,
  input  logic        disp_rdy1,
  input  logic [15:0] disp_val0,
  input  logic [15:0] disp_val1,
  input  logic [5:0]  disp_tag0,
  input  logic [5:0]  disp_tag1,
  output logic        disp_full,
  output logic [5:0]  disp_rs_num,
  input  logic        cdb_valid,
  input  logic [5:0]  cdb_rs_num,
  input  logic [15:0] cdb_data,
  output logic        issue_valid,
  output logic [5:0]  issue_rs_num,
  output logic [3:0]  issue_op,
  output logic [15:0] issue_pc,
  output logic [15:0] issue_val0,
  output logic [15:0] issue_val1,
  input  logic        ld_busy
);

  localparam int unsigned IDX_W = $clog2(N_ENTRIES);

  logic [N_ENTRIES-1:0] ent_valid, ent_ready, alloc_c, free_c;
  logic [OP_W-1:0]      ent_op   [N_ENTRIES];
  logic [PC_W-1:0]      ent_pc   [N_ENTRIES];
  logic [DATA_W-1:0]    ent_val0 [N_ENTRIES];
  logic [DATA_W-1:0]    ent_val1 [N_ENTRIES];

  logic [IDX_W-1:0] free_idx_c, rdy_idx_c;
  logic             any_free_c, any_rdy_c, disp_go_c, issue_go_c;
  ld_payload_t      sel_c;

  logic             issue_valid_q, issue_valid_d;
  logic [TAG_W-1:0] issue_rs_q, issue_rs_d;
  ld_payload_t      issue_pl_q, issue_pl_d;

  for (genvar g = 0; g < N_ENTRIES; g++) begin : g_ent
    ld_rs_entry u_entry (
      .clk        (clk),
      .rst_n      (rst_n),
      .alloc      (alloc_c[g]),
      .free       (free_c[g]),
      .disp_op    (disp_op),
      .disp_pc    (disp_pc),
      .disp_rdy0  (disp_rdy0),
      .disp_rdy1  (disp_rdy1),
      .disp_val0  (disp_val0),
      .disp_val1  (disp_val1),
      .disp_tag0  (disp_tag0),
      .disp_tag1  (disp_tag1),
      .cdb_valid  (cdb_valid),
      .cdb_rs_num (cdb_rs_num),
      .cdb_data   (cdb_data),
      .valid      (ent_valid[g]),
      .op         (ent_op[g]),
      .pc         (ent_pc[g]),
      .val0       (ent_val0[g]),
      .val1       (ent_val1[g]),
      .ready_c    (ent_ready[g])
    );
  end

  // Lowest-index free / ready encoders, allocation and issue selection.
  always_comb begin
    free_idx_c = '0;
    rdy_idx_c  = '0;
    any_free_c = 1'b0;
    any_rdy_c  = 1'b0;
    alloc_c    = '0;
    free_c     = '0;
    sel_c      = PAYLOAD_RST;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (!ent_valid[i]) begin
        free_idx_c = IDX_W'(i);
        any_free_c = 1'b1;
      end
      if (ent_ready[i]) begin
        rdy_idx_c = IDX_W'(i);
        any_rdy_c = 1'b1;
      end
    end
    disp_go_c  = disp_valid && any_free_c;
    // Holding off for one cycle after an issue keeps issue_valid a single-cycle pulse.
    issue_go_c = any_rdy_c && !ld_busy && !issue_valid_q;
    for (int i = 0; i < N_ENTRIES; i++) begin
      alloc_c[i] = disp_go_c && (free_idx_c == IDX_W'(i));
      free_c[i]  = issue_go_c && (rdy_idx_c == IDX_W'(i));
      if (rdy_idx_c == IDX_W'(i)) begin
        sel_c = '{op: ent_op[i], pc: ent_pc[i], val0: ent_val0[i], val1: ent_val1[i]};
      end
    end
  end

  // Issue register next-state: load new fields on issue, otherwise hold data.
  always_comb begin
    issue_valid_d = issue_go_c;
    issue_rs_d    = issue_rs_q;
    issue_pl_d    = issue_pl_q;
    if (issue_go_c) begin
      issue_rs_d = RS_BASE + TAG_W'(rdy_idx_c);
      issue_pl_d = sel_c;
    end
  end

  // Issue output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_valid_q <= 1'b0;
      issue_rs_q    <= TAG_RST;
      issue_pl_q    <= PAYLOAD_RST;
    end else begin
      issue_valid_q <= issue_valid_d;
      issue_rs_q    <= issue_rs_d;
      issue_pl_q    <= issue_pl_d;
    end
  end

  assign disp_full    = !any_free_c;
  assign disp_rs_num  = RS_BASE + TAG_W'(free_idx_c);
  assign issue_valid  = issue_valid_q;
  assign issue_rs_num = issue_rs_q;
  assign issue_op     = issue_pl_q.op;
  assign issue_pc     = issue_pl_q.pc;
  assign issue_val0   = issue_pl_q.val0;
  assign issue_val1   = issue_pl_q.val1;

endmodule

// File: tb/tb_ld_rs.sv
// Directed, table-driven bench for the load reservation station.
module tb_ld_rs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        disp_valid = 1'b0;
  logic [3:0]  disp_op = '0;
  logic [15:0] disp_pc = '0;
  logic        disp_rdy0 = 1'b0, disp_rdy1 = 1'b0;
  logic [15:0] disp_val0 = '0, disp_val1 = '0;
  logic [5:0]  disp_tag0 = '0, disp_tag1 = '0;
  logic        disp_full;
  logic [5:0]  disp_rs_num;
  logic        cdb_valid = 1'b0;
  logic [5:0]  cdb_rs_num = '0;
  logic [15:0] cdb_data = '0;
  logic        issue_valid;
  logic [5:0]  issue_rs_num;
  logic [3:0]  issue_op;
  logic [15:0] issue_pc, issue_val0, issue_val1;
  logic        ld_busy = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  ld_rs dut (
    .clk(clk), .rst_n(rst_n),
    .disp_valid(disp_valid), .disp_op(disp_op), .disp_pc(disp_pc),
    .disp_rdy0(disp_rdy0), .disp_rdy1(disp_rdy1),
    .disp_val0(disp_val0), .disp_val1(disp_val1),
    .disp_tag0(disp_tag0), .disp_tag1(disp_tag1),
    .disp_full(disp_full), .disp_rs_num(disp_rs_num),
    .cdb_valid(cdb_valid), .cdb_rs_num(cdb_rs_num), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_rs_num(issue_rs_num), .issue_op(issue_op),
    .issue_pc(issue_pc), .issue_val0(issue_val0), .issue_val1(issue_val1),
    .ld_busy(ld_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dv;
    logic [3:0]  op;
    logic [15:0] pc;
    logic        r0;
    logic [15:0] v0;
    logic [5:0]  t0;
    logic        r1;
    logic [15:0] v1;
    logic [5:0]  t1;
    logic        cv;
    logic [5:0]  crs;
    logic [15:0] cd;
    logic        busy;
    logic        e_full;
    logic        chk_rs;
    logic [5:0]  e_rs;
    logic        e_iv;
    logic [5:0]  e_irs;
    logic [3:0]  e_op;
    logic [15:0] e_pc;
    logic [15:0] e_v0;
    logic        chk_v1;
    logic [15:0] e_v1;
  } vec_t;

  vec_t vecs[$];

  // Expected held issue fields (outputs keep their last issued values).
  logic [5:0]  h_rs = '0;
  logic [3:0]  h_op = '0;
  logic [15:0] h_pc = '0, h_v0 = '0;

  function automatic vec_t in_idle(input logic busy);
    vec_t r;
    r = '{default: '0};
    r.busy = busy;
    return r;
  endfunction

  function automatic vec_t in_disp(input logic [3:0] op, input logic [15:0] pc,
                                   input logic r0, input logic [15:0] v0, input logic [5:0] t0,
                                   input logic r1, input logic [15:0] v1, input logic [5:0] t1,
                                   input logic busy);
    vec_t r;
    r = in_idle(busy);
    r.dv = 1'b1; r.op = op; r.pc = pc;
    r.r0 = r0; r.v0 = v0; r.t0 = t0;
    r.r1 = r1; r.v1 = v1; r.t1 = t1;
    return r;
  endfunction

  function automatic vec_t with_cdb(input vec_t i, input logic [5:0] rs, input logic [15:0] d);
    vec_t r;
    r = i;
    r.cv = 1'b1; r.crs = rs; r.cd = d;
    return r;
  endfunction

  function automatic vec_t mk(input vec_t i, input logic f, input logic crs, input logic [5:0] rs,
                              input logic iv, input logic [5:0] irs = '0, input logic [3:0] op = '0,
                              input logic [15:0] pc = '0, input logic [15:0] v0 = '0,
                              input logic cv1 = 1'b0, input logic [15:0] v1 = '0);
    vec_t r;
    r = i;
    r.e_full = f; r.chk_rs = crs; r.e_rs = rs;
    r.e_iv = iv; r.e_irs = irs; r.e_op = op; r.e_pc = pc; r.e_v0 = v0;
    r.chk_v1 = cv1; r.e_v1 = v1;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t r);
    disp_valid = r.dv; disp_op = r.op; disp_pc = r.pc;
    disp_rdy0 = r.r0; disp_val0 = r.v0; disp_tag0 = r.t0;
    disp_rdy1 = r.r1; disp_val1 = r.v1; disp_tag1 = r.t1;
    cdb_valid = r.cv; cdb_rs_num = r.crs; cdb_data = r.cd;
    ld_busy = r.busy;
  endtask

  task automatic chk_issue(input string tag, input logic iv);
    chk({tag, ".issue_valid"}, 32'(issue_valid), 32'(iv));
    chk({tag, ".issue_rs_num"}, 32'(issue_rs_num), 32'(h_rs));
    chk({tag, ".issue_op"}, 32'(issue_op), 32'(h_op));
    chk({tag, ".issue_pc"}, 32'(issue_pc), 32'(h_pc));
    chk({tag, ".issue_val0"}, 32'(issue_val0), 32'(h_v0));
  endtask

  initial begin
    // Basic LD issue latency and entry reuse.
    vecs.push_back(mk(in_disp(4'd4, 16'h0010, 1, 16'h1234, 0, 0, 0, 0, 0), 0, 1, 6'd16, 0));
    vecs.push_back(mk(in_idle(0), 0, 1, 6'd17, 1, 6'd16, 4'd4, 16'h0010, 16'h1234));
    vecs.push_back(mk(in_idle(0), 0, 1, 6'd16, 0));
    // LDR waiting on tag 3; CDB arrives five cycles after dispatch.
    vecs.push_back(mk(in_disp(4'd5, 16'h0020, 1, 16'h0100, 0, 0, 0, 6'd3, 0), 0, 1, 6'd16, 0));
    for (int k = 0; k < 4; k++) vecs.push_back(mk(in_idle(0), 0, 1, 6'd17, 0));
    vecs.push_back(mk(with_cdb(in_idle(0), 6'd3, 16'h0020), 0, 1, 6'd17, 0));
    vecs.push_back(mk(in_idle(0), 0, 1, 6'd17, 1, 6'd16, 4'd5, 16'h0020, 16'h0100, 1, 16'h0020));
    // Dispatch-time CDB bypass on operand 0.
    vecs.push_back(mk(with_cdb(in_disp(4'd4, 16'h0030, 0, 16'h0000, 6'd7, 0, 0, 0, 0), 6'd7, 16'hBEEF),
                      0, 1, 6'd16, 0));
    vecs.push_back(mk(in_idle(0), 0, 1, 6'd17, 1, 6'd16, 4'd4, 16'h0030, 16'hBEEF));
    vecs.push_back(mk(in_idle(0), 0, 1, 6'd16, 0));
    // Fill all four entries while busy, drop a fifth, then drain in index order.
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(in_disp(4'd4, 16'h0040 + 16'(k), 1, 16'h00A0 + 16'(k), 0, 0, 0, 0, 1),
                        0, 1, 6'd16 + 6'(k), 0));
    vecs.push_back(mk(in_disp(4'd4, 16'h0044, 1, 16'h00A4, 0, 0, 0, 0, 1), 1, 0, 6'd0, 0));
    vecs.push_back(mk(in_idle(0), 1, 0, 6'd0, 1, 6'd16, 4'd4, 16'h0040, 16'h00A0));
    vecs.push_back(mk(in_idle(0), 0, 1, 6'd16, 0));
    vecs.push_back(mk(in_idle(0), 0, 1, 6'd16, 1, 6'd17, 4'd4, 16'h0041, 16'h00A1));
    vecs.push_back(mk(in_idle(0), 0, 1, 6'd16, 0));
    vecs.push_back(mk(in_idle(0), 0, 1, 6'd16, 1, 6'd18, 4'd4, 16'h0042, 16'h00A2));
    vecs.push_back(mk(in_idle(0), 0, 1, 6'd16, 0));
    vecs.push_back(mk(in_idle(0), 0, 1, 6'd16, 1, 6'd19, 4'd4, 16'h0043, 16'h00A3));
    vecs.push_back(mk(in_idle(0), 0, 1, 6'd16, 0));
    vecs.push_back(mk(in_idle(0), 0, 1, 6'd16, 0));

    // Reset state.
    #12;
    chk("rst.issue_valid", 32'(issue_valid), 32'd0);
    chk("rst.disp_full", 32'(disp_full), 32'd0);
    rst_n = 1'b1;
    tick();
    chk_issue("post_rst", 1'b0);
    chk("post_rst.disp_rs_num", 32'(disp_rs_num), 32'd16);

    foreach (vecs[n]) begin
      drive(vecs[n]);
      #1;
      chk($sformatf("v%0d.disp_full", n), 32'(disp_full), 32'(vecs[n].e_full));
      if (vecs[n].chk_rs)
        chk($sformatf("v%0d.disp_rs_num", n), 32'(disp_rs_num), 32'(vecs[n].e_rs));
      tick();
      if (vecs[n].e_iv) begin
        h_rs = vecs[n].e_irs; h_op = vecs[n].e_op; h_pc = vecs[n].e_pc; h_v0 = vecs[n].e_v0;
      end
      chk_issue($sformatf("v%0d", n), vecs[n].e_iv);
      if (vecs[n].chk_v1)
        chk($sformatf("v%0d.issue_val1", n), 32'(issue_val1), 32'(vecs[n].e_v1));
    end

    // Busy held for 20 cycles with a ready entry: no issue until released, then exactly one.
    drive(in_disp(4'd4, 16'h0050, 1, 16'h5555, 0, 0, 0, 0, 1));
    tick();
    drive(in_idle(1));
    for (int k = 0; k < 20; k++) begin
      tick();
      chk($sformatf("busy%0d.issue_valid", k), 32'(issue_valid), 32'd0);
    end
    drive(in_idle(0));
    tick();
    h_rs = 6'd16; h_op = 4'd4; h_pc = 16'h0050; h_v0 = 16'h5555;
    chk_issue("busy_rel", 1'b1);
    tick();
    chk_issue("busy_rel+1", 1'b0);
    tick();
    chk_issue("busy_rel+2", 1'b0);
    chk("busy_rel+2.disp_full", 32'(disp_full), 32'd0);

    // Mid-stream reset with three entries pending and issue_valid high.
    for (int k = 0; k < 4; k++) begin
      drive(in_disp(4'd4, 16'h0060 + 16'(k), 1, 16'h0B00 + 16'(k), 0, 0, 0, 0, 1));
      tick();
    end
    drive(in_idle(0));
    tick();
    h_rs = 6'd16; h_op = 4'd4; h_pc = 16'h0060; h_v0 = 16'h0B00;
    chk_issue("pre_rst", 1'b1);
    ld_busy = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    h_rs = '0; h_op = '0; h_pc = '0; h_v0 = '0;
    chk_issue("mid_rst", 1'b0);
    chk("mid_rst.issue_val1", 32'(issue_val1), 32'd0);
    chk("mid_rst.disp_full", 32'(disp_full), 32'd0);
    #1;
    rst_n = 1'b1;
    ld_busy = 1'b0;
    tick();
    chk_issue("after_rst", 1'b0);
    chk("after_rst.disp_full", 32'(disp_full), 32'd0);
    chk("after_rst.disp_rs_num", 32'(disp_rs_num), 32'd16);
    tick();
    chk_issue("after_rst+1", 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
